// File: rtl/if_id_pipe_reg.sv
// ---------------------------------------------------------------------------
// if_id_pipe_reg
//   Fetch-to-decode pipeline register with valid/ready handshakes on both
//   sides, synchronous flush and an optional second (skid) entry. An empty
//   stage presents NOP_INST / PC 0 so decode never sees stale data. A
//   saturating counter records cycles where decode back-pressures a valid
//   entry.
//
//   Build option: define IF_ID_SKID_EN to add the skid entry and SKID state;
//   in_ready then comes straight from a flop. Without it the stage holds one
//   entry and in_ready = empty || out_ready (combinational).
//
// Parameters
//   INST_W   instruction width
//   PC_W     program-counter width
//   NOP_INST instruction presented while empty
//   CNT_W    stall counter width
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                drop all held entries (highest priority)
//   in_valid/in_ready    fetch-side handshake, in_inst/in_pc payload
//   out_valid/out_ready  decode-side handshake, out_inst/out_pc payload
//   cnt_clr              synchronous clear of stall_cnt
//   stall_cnt            saturating count of out_valid && !out_ready cycles
// ---------------------------------------------------------------------------
module if_id_pipe_reg #(
    parameter int                INST_W   = 32,
    parameter int                PC_W     = 32,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013),
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
`ifdef IF_ID_SKID_EN
    localparam logic [1:0] ST_SKID  = 2'd2;
`endif

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [INST_W-1:0] r_main_inst;
    logic [PC_W-1:0]   r_main_pc;
    logic [INST_W-1:0] w_main_inst_nxt;
    logic [PC_W-1:0]   w_main_pc_nxt;
    logic              w_load_main;
    logic              w_in_xfer;
    logic              w_out_xfer;
    logic [CNT_W-1:0]  r_cnt;

`ifdef IF_ID_SKID_EN
    logic [INST_W-1:0] r_skid_inst;
    logic [PC_W-1:0]   r_skid_pc;
    logic              r_in_ready;
    logic              w_load_skid;
    logic              w_take_skid;
`endif

    assign out_valid  = (r_state != ST_EMPTY);
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

`ifdef IF_ID_SKID_EN
    // Ready is a flop loaded from the next state, so out_ready never
    // reaches in_ready combinationally.
    assign in_ready = r_in_ready;
`else
    assign in_ready = (r_state == ST_EMPTY) || out_ready;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_load_main = 1'b0;
`ifdef IF_ID_SKID_EN
        w_load_skid = 1'b0;
        w_take_skid = 1'b0;
`endif
        if (flush) begin
            // Any input transfer this cycle is dropped with the held entries.
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        w_load_main = 1'b1;
                        w_state_nxt = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (w_out_xfer && w_in_xfer) begin
                        w_load_main = 1'b1;
                    end else if (w_out_xfer) begin
                        w_state_nxt = ST_EMPTY;
`ifdef IF_ID_SKID_EN
                    end else if (w_in_xfer) begin
                        w_load_skid = 1'b1;
                        w_state_nxt = ST_SKID;
`endif
                    end
                end
`ifdef IF_ID_SKID_EN
                ST_SKID: begin
                    if (w_out_xfer) begin
                        w_load_main = 1'b1;
                        w_take_skid = 1'b1;
                        w_state_nxt = ST_FULL;
                    end
                end
`endif
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

`ifdef IF_ID_SKID_EN
    assign w_main_inst_nxt = w_take_skid ? r_skid_inst : in_inst;
    assign w_main_pc_nxt   = w_take_skid ? r_skid_pc   : in_pc;
`else
    assign w_main_inst_nxt = in_inst;
    assign w_main_pc_nxt   = in_pc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_inst <= '0;
            r_main_pc   <= '0;
        end else if (w_load_main) begin
            r_main_inst <= w_main_inst_nxt;
            r_main_pc   <= w_main_pc_nxt;
        end
    end

`ifdef IF_ID_SKID_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_inst <= '0;
            r_skid_pc   <= '0;
            r_in_ready  <= 1'b1;
        end else begin
            if (w_load_skid) begin
                r_skid_inst <= in_inst;
                r_skid_pc   <= in_pc;
            end
            r_in_ready <= (w_state_nxt != ST_SKID);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (out_valid && !out_ready && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_cnt;
    assign out_inst  = out_valid ? r_main_inst : NOP_INST;
    assign out_pc    = out_valid ? r_main_pc : '0;

endmodule
